register: RTL and testbench

REGISTER -- requirements
Module: register

---
 rtl/register.sv | 94 +++++++++
 tb/tb_register.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register
//   Enabled WIDTH-bit storage register with a sticky "has been loaded" flag.
//   On every rising CLK edge where Enable is high, DataIn is captured into
//   DataOut. When Enable is low, DataOut holds its value whatever DataIn does.
//   Valid rises on the first load after reset and stays high until the next
//   reset. RST_n clears the register asynchronously.
//
//   Optional feature (macro REGISTER_PARITY_EN):
//     When defined, the Parity output is added. It carries the even parity
//     (XOR of all bits) of DataOut and is held in its own flop, so it changes
//     on the same edge as DataOut. When the macro is undefined, the port and
//     its flop are absent.
//
// Parameters
//   WIDTH        data path width, 1..64
//   RESET_VALUE  value DataOut takes while RST_n is low
//
// Ports
//   CLK      in   1      clock, rising-edge active
//   RST_n    in   1      asynchronous reset, active low
//   Enable   in   1      load enable, sampled at the rising edge
//   DataIn   in   WIDTH  data to capture
//   DataOut  out  WIDTH  registered data, driven straight from flops
//   Valid    out  1      high once at least one load has happened since reset
//   Parity   out  1      XOR of DataOut bits (REGISTER_PARITY_EN only)
// ---------------------------------------------------------------------------
module register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             Enable,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut,
    output logic             Valid
`ifdef REGISTER_PARITY_EN
    ,
    output logic             Parity
`endif
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    // The mux selects data_q whenever Enable is low, so an unknown DataIn
    // never reaches the flops unless it is actually being loaded.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (Enable) begin
            data_d  = DataIn;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            data_q  <= RESET_VALUE;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DataOut = data_q;
    assign Valid   = valid_q;

`ifdef REGISTER_PARITY_EN
    logic parity_d;
    logic parity_q;

    // Parity is taken from the next data value and stored alongside it, so
    // it is cycle-aligned with DataOut and needs no output XOR tree.
    always_comb begin
        parity_d = ^data_d;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            parity_q <= ^RESET_VALUE;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign Parity = parity_q;
`endif

endmodule

// File: tb/tb_register.sv
module tb_register;

    localparam int         W     = 8;
    localparam logic [7:0] RST_V = 8'h00;

    logic         CLK;
    logic         RST_n;
    logic         Enable;
    logic [W-1:0] DataIn;
    logic [W-1:0] DataOut;
    logic         Valid;
`ifdef REGISTER_PARITY_EN
    logic         Parity;
`endif

    register #(
        .WIDTH      (W),
        .RESET_VALUE(RST_V)
    ) dut (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .Enable (Enable),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .Valid  (Valid)
`ifdef REGISTER_PARITY_EN
        ,
        .Parity (Parity)
`endif
    );

    // 60 ns clock period, rising edges at 30, 90, 150, ...
    initial CLK = 1'b0;
    always #30 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] d;
        logic         v;
        logic         p;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] loads[$];   // history of values loaded since the last reset
    int           tests = 0;
    int           fails = 0;

    // Reference model: DataOut is the most recent load since reset (or the
    // reset value if there was none), Valid says whether any load happened,
    // Parity is the count of ones in DataOut modulo 2.
    always @(posedge CLK or negedge RST_n) begin
        exp_t e;
        if (RST_n !== 1'b1) begin
            loads.delete();
        end else if (Enable === 1'b1) begin
            loads.push_back(DataIn);
        end
        e.d = (loads.size() != 0) ? loads[$] : RST_V;
        e.v = (loads.size() != 0);
        e.p = 1'($countones(e.d) % 2);
        exp_q.push_back(e);
    end

    // Monitor: the DUT presents a new output after every rising edge and
    // after every reset assertion; compare 1 ns later.
    always @(posedge CLK or negedge RST_n) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got no expectation at %0t, required one", $time);
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (DataOut !== e.d) begin
                fails++;
                $display("FAIL data_out at %0t: got %h required %h", $time, DataOut, e.d);
            end
            tests++;
            if (Valid !== e.v) begin
                fails++;
                $display("FAIL valid at %0t: got %b required %b", $time, Valid, e.v);
            end
`ifdef REGISTER_PARITY_EN
            tests++;
            if (Parity !== e.p) begin
                fails++;
                $display("FAIL parity at %0t: got %b required %b", $time, Parity, e.p);
            end
`endif
        end
    end

    initial begin
        // Reset held with Enable high and DataIn=A5 while the clock runs.
        RST_n  = 1'b0;
        Enable = 1'b1;
        DataIn = 8'hA5;
        repeat (4) @(posedge CLK);

        // Release and load 3C on one edge.
        @(negedge CLK);
        RST_n  = 1'b1;
        Enable = 1'b1;
        DataIn = 8'h3C;
        @(posedge CLK);
        #10;
        Enable = 1'b0;

        // Hold for 5 edges while DataIn changes every 20 ns.
        for (int i = 0; i < 15; i++) begin
            DataIn = W'($urandom);
            #20;
        end

        // Async reset between edges, then edges with Enable high during reset.
        #5;
        RST_n  = 1'b0;
        #5;
        Enable = 1'b1;
        DataIn = 8'h5A;
        repeat (2) @(posedge CLK);

        // Release; first enabled edge loads normally.
        @(negedge CLK);
        RST_n  = 1'b1;
        DataIn = 8'hC3;
        @(posedge CLK);

        // Directed parity values: 07 (odd count) then 03 (even count).
        #10;
        DataIn = 8'h07;
        @(posedge CLK);
        #10;
        DataIn = 8'h03;
        @(posedge CLK);
        #10;

        // Enable toggles every 100 ns, DataIn changes every 20 ns, sometimes
        // unknown while Enable is low; one async reset pulse mid-run.
        Enable = 1'b0;
        for (int j = 0; j < 150; j++) begin
            if (j % 5 == 0) Enable = ~Enable;
            if (!Enable && $urandom_range(0, 3) == 0)
                DataIn = 'x;
            else
                DataIn = W'($urandom);
            if (j == 70) RST_n = 1'b0;
            if (j == 73) RST_n = 1'b1;
            #20;
        end

        Enable = 1'b0;
        repeat (2) @(negedge CLK);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
